// File: rtl/lcd_bus_writer.sv
// HD44780-style LCD bus writer: one byte per valid/ready handshake, driven onto E/RS/RW/D
// with setup, enable pulse, hold, inter-nibble gap and post-command wait timing.
module lcd_bus_writer #(
    parameter int unsigned BUS_W     = 4,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 12,
    parameter int unsigned HOLD_CYC  = 1,
    parameter int unsigned GAP_CYC   = 50,
    parameter int unsigned WAIT_CYC  = 2000,
    parameter int unsigned LWAIT_CYC = 82000,
    parameter int unsigned CNT_W     = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rs,
    input  logic [7:0]       cmd_data,
    input  logic             cmd_nib_only,
    input  logic             cmd_long,
    output logic             done,
    output logic             lcd_e,
    output logic             lcd_rs,
    output logic             lcd_rw,
    output logic [BUS_W-1:0] lcd_d
);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, GAP, WAIT} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, lim;
    logic             last;
    logic             rs_q, nib_q, long_q, low_q;
    logic             rs_n, nib_n, long_n, low_n;
    logic [7:0]       data_q, data_n;
    logic             e_n, lrs_n, ready_n, done_n;
    logic [BUS_W-1:0] d_n;

    // Terminal count for a timed state; a programmed length of 0 behaves as 1.
    function automatic logic [CNT_W-1:0] lim_of(input int unsigned c);
        return (c == 0) ? '0 : CNT_W'(c - 1);
    endfunction

    function automatic logic [BUS_W-1:0] field(input logic [7:0] b, input logic low);
        logic [3:0] nib;
        nib = low ? b[3:0] : b[7:4];
        if (BUS_W == 8) return BUS_W'(b);
        else            return BUS_W'(nib);
    endfunction

    always_comb begin
        lim = '0;
        case (state)
            SETUP:   lim = lim_of(SETUP_CYC);
            PULSE:   lim = lim_of(PULSE_CYC);
            HOLD:    lim = lim_of(HOLD_CYC);
            GAP:     lim = lim_of(GAP_CYC);
            WAIT:    lim = long_q ? lim_of(LWAIT_CYC) : lim_of(WAIT_CYC);
            default: lim = '0;
        endcase
        last = (cnt == lim);
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        rs_n    = rs_q;
        nib_n   = nib_q;
        long_n  = long_q;
        low_n   = low_q;
        data_n  = data_q;
        e_n     = 1'b0;
        lrs_n   = 1'b0;
        d_n     = lcd_d;
        ready_n = 1'b0;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_n = SETUP;
                    rs_n    = cmd_rs;
                    data_n  = cmd_data;
                    nib_n   = cmd_nib_only;
                    long_n  = cmd_long;
                    low_n   = 1'b0;
                end
            end
            SETUP: if (last) state_n = PULSE;
            PULSE: if (last) state_n = HOLD;
            HOLD: begin
                if (last) begin
                    if (BUS_W == 4 && !low_q && !nib_q) state_n = GAP;
                    else                                 state_n = WAIT;
                end
            end
            GAP: begin
                if (last) begin
                    low_n   = 1'b1;
                    state_n = SETUP;
                end
            end
            WAIT: begin
                if (last) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (state_n != state || state_n == IDLE) cnt_n = '0;

        // Pin values are decoded from the next state so they register alongside it.
        case (state_n)
            IDLE: begin
                ready_n = 1'b1;
                d_n     = '0;
            end
            SETUP, PULSE, HOLD: begin
                e_n   = (state_n == PULSE);
                lrs_n = rs_n;
                d_n   = field(data_n, low_n);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rs_q      <= 1'b0;
            nib_q     <= 1'b0;
            long_q    <= 1'b0;
            low_q     <= 1'b0;
            data_q    <= '0;
            cmd_ready <= 1'b1;
            done      <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_d     <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rs_q      <= rs_n;
            nib_q     <= nib_n;
            long_q    <= long_n;
            low_q     <= low_n;
            data_q    <= data_n;
            cmd_ready <= ready_n;
            done      <= done_n;
            lcd_e     <= e_n;
            lcd_rs    <= lrs_n;
            lcd_d     <= d_n;
        end
    end

    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Randomised bench for lcd_bus_writer: 4-bit and 8-bit instances checked cycle by cycle
// against an expected pin waveform built from the timing segments of each command.
module tb_lcd_bus_writer;

    localparam int unsigned S = 2, P = 4, H = 1, G = 3, W = 5, LW = 9;

    logic       clk, reset;
    logic       valid4, valid8, rdy4, rdy8;
    logic       rs, nib, lng;
    logic [7:0] data;
    logic       done4, done8, e4, e8, rso4, rso8, rw4, rw8;
    logic [3:0] d4;
    logic [7:0] d8;

    lcd_bus_writer #(.BUS_W(4), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .GAP_CYC(G),
                     .WAIT_CYC(W), .LWAIT_CYC(LW), .CNT_W(8)) dut4 (
        .clk(clk), .reset(reset), .cmd_valid(valid4), .cmd_ready(rdy4), .cmd_rs(rs),
        .cmd_data(data), .cmd_nib_only(nib), .cmd_long(lng), .done(done4),
        .lcd_e(e4), .lcd_rs(rso4), .lcd_rw(rw4), .lcd_d(d4));

    lcd_bus_writer #(.BUS_W(8), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .GAP_CYC(G),
                     .WAIT_CYC(W), .LWAIT_CYC(LW), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .cmd_valid(valid8), .cmd_ready(rdy8), .cmd_rs(rs),
        .cmd_data(data), .cmd_nib_only(nib), .cmd_long(lng), .done(done8),
        .lcd_e(e8), .lcd_rs(rso8), .lcd_rw(rw8), .lcd_d(d8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       e;
        logic       rs;
        logic [7:0] d;
        logic       ready;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   sel8 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic push(input logic e, input logic r, input logic [7:0] d,
                        input logic rdy, input logic dn);
        exp_t x;
        x.e = e; x.rs = r; x.d = d; x.ready = rdy; x.done = dn;
        exp_q.push_back(x);
    endtask

    task automatic push_pulse(input logic r, input logic [7:0] f);
        repeat (S) push(1'b0, r, f, 1'b0, 1'b0);
        repeat (P) push(1'b1, r, f, 1'b0, 1'b0);
        repeat (H) push(1'b0, r, f, 1'b0, 1'b0);
    endtask

    // Expected pin trace for cycles 1..done after the handshake edge.
    task automatic model_cmd(input bit b8, input logic r, input logic [7:0] dt,
                             input logic nb, input logic lg);
        logic [7:0] f;
        f = b8 ? dt : {4'h0, dt[7:4]};
        push_pulse(r, f);
        if (!b8 && !nb) begin
            repeat (G) push(1'b0, 1'b0, f, 1'b0, 1'b0);
            f = {4'h0, dt[3:0]};
            push_pulse(r, f);
        end
        repeat (lg ? LW : W) push(1'b0, 1'b0, f, 1'b0, 1'b0);
        push(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic cmp_cycle(output logic obs_done);
        exp_t x;
        x = exp_q.pop_front();
        obs_done = sel8 ? done8 : done4;
        check("lcd_e",     sel8 ? e8 : e4,          x.e);
        check("lcd_rs",    sel8 ? rso8 : rso4,      x.rs);
        check("lcd_d",     sel8 ? d8 : {4'h0, d4},  x.d);
        check("cmd_ready", sel8 ? rdy8 : rdy4,      x.ready);
        check("done",      obs_done,                x.done);
        check("lcd_rw",    {rw8, rw4},              2'b00);
        check("other_e",   sel8 ? e4 : e8,          1'b0);
    endtask

    // Entered and left at a negedge where the target is idle; returns in its done cycle.
    task automatic do_cmd(input bit b8, input logic r, input logic [7:0] dt,
                          input logic nb, input logic lg, output int done_at);
        int   len;
        logic od;
        done_at = 0;
        sel8    = b8;
        valid4  = !b8;
        valid8  = b8;
        rs = r; data = dt; nib = nb; lng = lg;
        model_cmd(b8, r, dt, nb, lg);
        len = exp_q.size();
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            cmp_cycle(od);
            if (od === 1'b1 && done_at == 0) done_at = i;
            if (i < len) begin
                rs   = 1'($urandom);
                data = 8'($urandom);
                nib  = 1'($urandom);
                lng  = 1'($urandom);
                if (b8) valid8 = 1'($urandom);
                else    valid4 = 1'($urandom);
            end
        end
    endtask

    task automatic idle_gap(input int n);
        valid4 = 1'b0;
        valid8 = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("idle_ready", {rdy8, rdy4}, 2'b11);
            check("idle_e",     {e8, e4},     2'b00);
            check("idle_done",  {done8, done4}, 2'b00);
            check("idle_d",     {d8, d4},     12'h000);
        end
    endtask

    int dn;

    initial begin
        reset = 1'b1;
        valid4 = 1'b0; valid8 = 1'b0;
        rs = 1'b0; data = 8'h00; nib = 1'b0; lng = 1'b0;
        #1;
        check("rst_ready", {rdy8, rdy4},   2'b11);
        check("rst_done",  {done8, done4}, 2'b00);
        check("rst_e",     {e8, e4},       2'b00);
        check("rst_rs",    {rso8, rso4},   2'b00);
        check("rst_rw",    {rw8, rw4},     2'b00);
        check("rst_d",     {d8, d4},       12'h000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle_gap(2);

        do_cmd(1'b0, 1'b0, 8'h28, 1'b0, 1'b0, dn);
        check("t1_done_cycle", dn, 23);
        idle_gap(2);
        do_cmd(1'b0, 1'b0, 8'h30, 1'b1, 1'b0, dn);
        check("t2_done_cycle", dn, 13);
        idle_gap(1);
        do_cmd(1'b1, 1'b0, 8'h01, 1'b0, 1'b1, dn);
        check("t3_done_cycle", dn, 17);
        idle_gap(1);
        // Back-to-back: second command offered in the first one's done cycle.
        do_cmd(1'b0, 1'b1, 8'h41, 1'b0, 1'b0, dn);
        check("t6_done_cycle", dn, 23);
        do_cmd(1'b0, 1'b0, 8'h0C, 1'b0, 1'b0, dn);
        check("t4_b2b_done_cycle", dn, 23);
        idle_gap(1);

        // Reset during the first enable pulse.
        sel8 = 1'b0; valid4 = 1'b1; rs = 1'b1; data = 8'h5A; nib = 1'b0; lng = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_pre_e", e4, 1'b1);
        valid4 = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("t5_async_e",     e4,    1'b0);
        check("t5_async_ready", rdy4,  1'b1);
        check("t5_async_d",     d4,    4'h0);
        check("t5_async_rs",    rso4,  1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle_gap(25);

        for (int k = 0; k < 40; k++) begin
            do_cmd(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), dn);
            if ($urandom_range(2, 0) != 0) idle_gap(int'($urandom_range(3, 1)));
        end
        idle_gap(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
